jtkcpu_mdu: RTL
===============

# jtkcpu_mdu

Sequential multiply/divide unit for the KONAMI-2 CPU core, parametrised in operand width. It sits beside the combinational ALU and handles the multi-cycle operations: MUL, LMUL and DIVX. It uses a shift-add / restoring-divide datapath that retires one bit per enabled clock. The CPU sequencer starts an operation and stalls until `done`, then writes `rslt_hi`/`rslt_lo` and the flags back to the register file and CC.

## Interface
- `W`, 16, operand width in bits; even, ≥8. Half width `H = W/2`.

- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `cen`  in  1  clock enable; all state advances only on `cen`-qualified edges
- `start`  in  1  request; accepted when `busy=0`
- `op`  in  2  0=MUL (H×H→W), 1=LMUL (W×W→2W), 2=DIV (W÷H), 3=reserved (completes as DIV-by-zero)
- `opnd0`  in  W  multiplicand / dividend
- `opnd1`  in  W  multiplier / divisor; MUL and DIV use `[H-1:0]` only
- `busy`  out  1  operation in progress
- `done`  out  1  one-`cen`-cycle completion pulse
- `rslt_hi`  out  W  LMUL high word / DIV remainder (zero-extended); 0 for MUL
- `rslt_lo`  out  W  MUL/LMUL low word / DIV quotient
- `c_out`, `z_out`, `v_out`  out  1 each  carry, zero and overflow flags

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `start` latches `op` and the operands, then clears the accumulator and iteration counter.
  - It then goes to RUN, or to DONE directly for divide-by-zero or `op=3`.
- Iteration count N: MUL = H, LMUL = W, DIV = W.
- RUN:
  - Each `cen` edge performs one step:
    - Multiply: if the multiplier LSB is set, add the multiplicand to the upper accumulator; then shift right.
    - Divide: shift the remainder/quotient left; trial-subtract the divisor; keep the result and set the quotient bit if there is no borrow.
  - After step N, go to DONE.
- DONE:
  - `done=1` for one `cen` cycle; results and flags are valid.
  - Then go to IDLE.
  - Results and flags hold until the next accepted `start` or `rst`.
- Flags:
  - MUL: `c` = `rslt_lo[H-1]`; `z` = product==0; `v` = 0.
  - LMUL: `c` = `rslt_lo[W-1]`; `z` = 2W-bit product==0; `v` = 0.
  - DIV: `c` = quotient`[H-1]`; `z` = quotient==0; `v` = 0.
  - DIV with divisor 0, and `op=3`: quotient all ones, remainder = `opnd0[H-1:0]`, `v=1`, `c=1`, `z=0`.
- All arithmetic is unsigned. The quotient always fits in W bits.

## Timing
- Reset: `busy=0`, `done=0`, `rslt_hi=0`, `rslt_lo=0`, `c_out=z_out=v_out=0`, state IDLE.
- `rst` wins over everything, including mid-operation: the operation is aborted and no `done` is produced.
- With `cen` held high and `start` presented in cycle 0:
  - `busy=1` in cycles 1..N.
  - `done=1` with `busy=0` in cycle N+1.
  - MUL = 9 cycles, LMUL/DIV = 17 cycles at W=16.
  - Divide-by-zero: `done` in cycle 1.
- `start` while `busy=1` or in the DONE cycle is ignored. The next accepted `start` is the cycle after `done`.
- `cen=0` freezes the state, counter, `busy` and `done`. A `done` pulse therefore lasts until the next `cen` edge.
- Operand changes after acceptance have no effect.

## Configuration
- Macro: `JTKCPU_DIV_EN`.
- Defined: the DIV path (trial subtractor and quotient logic) is built as described above.
- Undefined:
  - The divider is omitted.
  - `op=2` behaves as `op=3`: `done` in cycle 1, quotient all ones, remainder `opnd0[H-1:0]`, `v=1`, `c=1`.
  - The MUL and LMUL paths are unaffected.

## Structure
- Package `jtkcpu_mdu_pkg` holds:
  - `op` encodings (`MDU_MUL`, `MDU_LMUL`, `MDU_DIV`).
  - State encodings.
  - The iteration-count function of `op` and `W`.
- Sub-module `jtkcpu_mdu_step`: combinational single-iteration datapath (conditional add + shift, trial subtract + shift). It is instantiated once, and registered by the `jtkcpu_mdu` FSM.

## Test plan
All scenarios use W=16 and `cen=1` unless stated.
1. MUL, `opnd0=0x00FF`, `opnd1=0x00FF` -> cycle 9: `done=1`, `rslt_lo=0xFE01`, `rslt_hi=0`, `c=0`, `z=0`.
2. LMUL, `0xFFFF`×`0xFFFF` -> cycle 17: `rslt_hi=0xFFFE`, `rslt_lo=0x0001`, `c=0`, `z=0`. LMUL `0x0000`×`0x1234` -> `z=1`.
3. DIV, `0x1234`÷`0x0056` -> cycle 17: `rslt_lo=0x0036`, `rslt_hi=0x0010`, `v=0`, `c=0`. DIV `0x1234`÷`0` -> cycle 1: `rslt_lo=0xFFFF`, `rslt_hi=0x0034`, `v=1`.
4. `rst` asserted in cycle 5 of an LMUL -> next cycle all outputs 0, no `done`. A `start` the following cycle completes normally.
5. `start` re-asserted while `busy` with different operands -> ignored; the first result is unchanged.
6. `cen` toggling 1/0 during a MUL -> `done` after 9 `cen` edges; the `done` pulse lasts until the next `cen` edge; results match scenario 1.

Source files
------------

// File: rtl/jtkcpu_mdu_pkg.sv
// Shared encodings for the KONAMI-2 multiply/divide unit.
// Holds op codes, FSM states and the per-op iteration count.
package jtkcpu_mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MUL  = 2'd0,
        MDU_LMUL = 2'd1,
        MDU_DIV  = 2'd2,
        MDU_RSV  = 2'd3
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mdu_st_e;

    // MUL only walks the low half of the multiplier; LMUL and DIV retire a full word
    function automatic int mdu_iters(mdu_op_e op, int w);
        return (op == MDU_MUL) ? w / 2 : w;
    endfunction

endpackage

// File: rtl/jtkcpu_mdu_if.sv
// Request/result bundle between the CPU sequencer and the multiply/divide unit.
// The sequencer drives the master side; the unit is the slave.
interface jtkcpu_mdu_if #(parameter int W = 16);
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] opnd0;
    logic [W-1:0] opnd1;
    logic         busy;
    logic         done;
    logic [W-1:0] rslt_hi;
    logic [W-1:0] rslt_lo;
    logic         c_out;
    logic         z_out;
    logic         v_out;

    modport master (
        output start, op, opnd0, opnd1,
        input  busy, done, rslt_hi, rslt_lo, c_out, z_out, v_out
    );

    modport slave (
        input  start, op, opnd0, opnd1,
        output busy, done, rslt_hi, rslt_lo, c_out, z_out, v_out
    );
endinterface

// File: rtl/jtkcpu_mdu_step.sv
// One combinational iteration: shift-add multiply or restoring-divide step.
// Zero latency; no handshake. Divider path exists only with JTKCPU_DIV_EN.
module jtkcpu_mdu_step #(
    parameter int W = 16
) (
`ifdef JTKCPU_DIV_EN
    input  logic           div,
    input  logic [W/2-1:0] dvsr,
`endif
    input  logic [W-1:0]   hi,
    input  logic [W-1:0]   lo,
    input  logic [W-1:0]   mcand,
    output logic [W-1:0]   hi_nxt,
    output logic [W-1:0]   lo_nxt
);
    localparam int H = W / 2;

    logic [W:0] sum;
`ifdef JTKCPU_DIV_EN
    logic [H:0]   r2;
    logic [H+1:0] diff;
`endif

    always_comb begin
        // carry out of the add shifts into the top of hi, so no bit is lost
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(W+1){1'b0}});
        hi_nxt = sum[W:1];
        lo_nxt = {sum[0], lo[W-1:1]};
`ifdef JTKCPU_DIV_EN
        r2   = {hi[H-1:0], lo[W-1]};
        diff = {1'b0, r2} - {2'b00, dvsr};
        if (div) begin
            if (!diff[H+1]) begin
                hi_nxt = {{H{1'b0}}, diff[H-1:0]};
                lo_nxt = {lo[W-2:0], 1'b1};
            end else begin
                hi_nxt = {{H{1'b0}}, r2[H-1:0]};
                lo_nxt = {lo[W-2:0], 1'b0};
            end
        end
`endif
    end

endmodule

// File: rtl/jtkcpu_mdu.sv
// Sequential MUL/LMUL/DIVX unit, one bit per cen edge; optional divider via JTKCPU_DIV_EN.
// Latency: MUL H+1, LMUL/DIV W+1 cycles, div-by-zero 1; start ignored unless idle.
module jtkcpu_mdu
    import jtkcpu_mdu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cen,
    jtkcpu_mdu_if.slave    bus
);
    localparam int H  = W / 2;
    localparam int CW = $clog2(W + 1);

    mdu_st_e      st;
    mdu_op_e      op_q;
    mdu_op_e      op_in;
    logic [W-1:0] mcand, acc_hi, acc_lo, hi_nxt, lo_nxt;
    logic [CW-1:0] cnt;
    logic         last, div_fault;
    logic         busy_q, done_q, c_q, z_q, v_q;
    logic [W-1:0] rhi_q, rlo_q;
    logic [W-1:0] res_hi, res_lo;
    logic         res_c, res_z;

    assign op_in = mdu_op_e'(bus.op);
    assign last  = (cnt == CW'(mdu_iters(op_q, W) - 1));

`ifdef JTKCPU_DIV_EN
    logic [H-1:0] dvsr;
    assign div_fault = (op_in == MDU_RSV) || ((op_in == MDU_DIV) && (bus.opnd1[H-1:0] == '0));

    jtkcpu_mdu_step #(.W(W)) u_step (
        .div    (op_q == MDU_DIV),
        .dvsr   (dvsr),
        .hi     (acc_hi),
        .lo     (acc_lo),
        .mcand  (mcand),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );
`else
    // without the divider both op=2 and op=3 finish as a divide-by-zero
    assign div_fault = bus.op[1];

    jtkcpu_mdu_step #(.W(W)) u_step (
        .hi     (acc_hi),
        .lo     (acc_lo),
        .mcand  (mcand),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );
`endif

    // final-step result, captured on the RUN->DONE edge
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        res_c  = 1'b0;
        res_z  = 1'b0;
        case (op_q)
            MDU_LMUL: begin
                res_hi = hi_nxt;
                res_lo = lo_nxt;
                res_c  = lo_nxt[W-1];
                res_z  = (hi_nxt == '0) && (lo_nxt == '0);
            end
`ifdef JTKCPU_DIV_EN
            MDU_DIV: begin
                res_hi = {{H{1'b0}}, hi_nxt[H-1:0]};
                res_lo = lo_nxt;
                res_c  = lo_nxt[H-1];
                res_z  = (lo_nxt == '0);
            end
`endif
            default: begin
                // after H steps the H x H product sits in the middle of {hi,lo}
                res_lo = {hi_nxt[H-1:0], lo_nxt[W-1:H]};
                res_c  = res_lo[H-1];
                res_z  = (res_lo == '0);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= ST_IDLE;
            op_q   <= MDU_MUL;
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rhi_q  <= '0;
            rlo_q  <= '0;
            c_q    <= 1'b0;
            z_q    <= 1'b0;
            v_q    <= 1'b0;
`ifdef JTKCPU_DIV_EN
            dvsr   <= '0;
`endif
        end else if (cen) begin
            case (st)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_q   <= op_in;
                        mcand  <= (op_in == MDU_MUL) ? {{H{1'b0}}, bus.opnd0[H-1:0]} : bus.opnd0;
                        acc_hi <= '0;
                        acc_lo <= (op_in == MDU_MUL)  ? {{H{1'b0}}, bus.opnd1[H-1:0]} :
                                  (op_in == MDU_LMUL) ? bus.opnd1 : bus.opnd0;
                        cnt    <= '0;
`ifdef JTKCPU_DIV_EN
                        dvsr   <= bus.opnd1[H-1:0];
`endif
                        if (div_fault) begin
                            st     <= ST_DONE;
                            done_q <= 1'b1;
                            rhi_q  <= {{H{1'b0}}, bus.opnd0[H-1:0]};
                            rlo_q  <= '1;
                            c_q    <= 1'b1;
                            z_q    <= 1'b0;
                            v_q    <= 1'b1;
                        end else begin
                            st     <= ST_RUN;
                            busy_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    acc_hi <= hi_nxt;
                    acc_lo <= lo_nxt;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        st     <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        rhi_q  <= res_hi;
                        rlo_q  <= res_lo;
                        c_q    <= res_c;
                        z_q    <= res_z;
                        v_q    <= 1'b0;
                    end
                end
                ST_DONE: begin
                    st     <= ST_IDLE;
                    done_q <= 1'b0;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rslt_hi = rhi_q;
    assign bus.rslt_lo = rlo_q;
    assign bus.c_out   = c_q;
    assign bus.z_out   = z_q;
    assign bus.v_out   = v_q;

endmodule
